floo_vc_credit_alloc: RTL and testbench
=======================================

Name: floo_vc_credit_alloc

Overview:
Per-output-port VC credit tracker and VC selector/assigner for the virtual-channel router.
- Holds one credit counter per downstream VC and selects an output VC for the flit that won global switch allocation.
- Selection prefers the VC carried in the lookahead header, with round-robin fallback.
- One instance per router output port; it sits between global SA and the SA→ST stage register.

Parameters:
NumVC, 4, number of downstream VCs on this output (1..8)
NumVCWidth, 2, width of VC ids; must be ≥ $clog2(NumVC), minimum 1
VCDepth, 2, buffer depth per downstream VC; counter reset value
CreditWidth, $clog2(VCDepth+1), width of each credit counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
pref_vc_id_i  in  NumVCWidth  preferred VC from lookahead header
pref_only_i  in  1  1: only the preferred VC may be assigned (no fallback)
vc_sel_v_o  out  1  a VC is available for assignment this cycle
vc_sel_id_o  out  NumVCWidth  selected VC
assign_v_i  in  1  global SA winner accepted; consume one credit of vc_sel_id_o
credit_v_i  in  1  credit returned from downstream
credit_id_i  in  NumVCWidth  VC of the returned credit
vc_avail_o  out  NumVC  per-VC credit>0 (registered state)
vc_credit_o  out  NumVC*CreditWidth  per-VC credit count, VC0 in LSBs
err_o  out  1  sticky protocol error

Behaviour:
Reset (async, rst_i=1):
- all counters = VCDepth; vc_avail_o = all ones; rr_ptr = 0; err_o = 0.
- vc_sel_v_o/vc_sel_id_o follow the selection rules from the reset state: v=1, id=pref if pref valid, else 0.

Selection (combinational from counters; zero cycle latency):
- pref_valid = pref_vc_id_i < NumVC.
- If pref_valid and credit[pref] > 0: sel = pref, v = 1.
- Else if pref_only_i = 1: v = 0, id = pref_vc_id_i.
- Else: search from rr_ptr upward, wrapping modulo NumVC; sel = first VC with credit > 0, v = 1.
- If no VC has credit: v = 0, id = 0.

Assignment (clock edge):
- assign_v_i=1 and v=1: credit[sel] decrements.
- If the fallback path was used: rr_ptr <= (sel+1) mod NumVC.
- Preferred-path assigns leave rr_ptr unchanged.
- assign_v_i=1 with v=0: no counter change; err_o <= 1.

Credit return (clock edge):
- credit_v_i=1: credit[credit_id_i] increments.
- Same cycle, same VC as an assign: net unchanged.
- Increment that would exceed VCDepth: counter saturates at VCDepth; err_o <= 1.
- credit_id_i ≥ NumVC: ignored; err_o <= 1.

Simultaneous events:
- Assign on VC a and return on VC b≠a: both applied.
- err_o stays set until reset.

Counter arithmetic is CreditWidth bits and never wraps: 0 saturates on decrement, VCDepth saturates on increment.

Reset mid-operation: all state returns to reset values immediately; in-flight credits are lost by design.

Outputs:
- vc_avail_o and vc_credit_o reflect registered counters only; bypass never affects them.
- No output is registered beyond the counters, rr_ptr and err_o.

Optional Feature:
FLOO_VC_CREDIT_BYPASS_EN
- Defined: a credit returned this cycle (credit_v_i, valid id) counts as available to this cycle's selection. Selection treats credit[id]+1 as the effective count, enabling back-to-back reuse of a depth-1 VC.
- Not defined: a returned credit becomes selectable the cycle after its return.
- Counter update semantics are identical in both cases.

Test Plan:
Defaults NumVC=4, VCDepth=2.
1. Assert then release rst_i asynchronously mid-cycle, pref=1 → vc_credit_o all 2, vc_avail_o=4'b1111, vc_sel_v_o=1, vc_sel_id_o=1, err_o=0.
2. pref=2, pref_only=0, assign twice → credit[2]=0. Third cycle: sel=0 via fallback (rr_ptr 0). Assign → credit[0]=1, rr_ptr=1. Next cycle sel=1.
3. credit[2]=0, pref=2, pref_only=1 → vc_sel_v_o=0. Then assign_v_i=1 → counters unchanged, err_o=1 and stays 1 after 10 idle cycles.
4. credit[1]=1, pref=1, assign_v_i=1 with credit_v_i=1, credit_id_i=1 in the same cycle → credit[1] stays 1, err_o=0.
5. credit[0]=2, credit_v_i=1, credit_id_i=0 → credit[0]=2 (saturated), err_o=1. Separately, credit_id_i=5 with NumVCWidth=3, NumVC=4 → ignored, err_o=1.
6. credit[3]=0, all other VCs 0, pref=3, pref_only=1, credit_v_i=1, id=3:
   - with FLOO_VC_CREDIT_BYPASS_EN: vc_sel_v_o=1, id=3 in the same cycle; assigning → credit[3]=0 next cycle.
   - without it: vc_sel_v_o=0 that cycle, 1 the next.

Source files
------------

// File: rtl/floo_vc_credit_alloc.sv
// Per-output-port downstream VC credit tracker with preferred/round-robin VC selection.
// Optional macro FLOO_VC_CREDIT_BYPASS_EN: credits returned this cycle are selectable this cycle.
module floo_vc_credit_alloc #(
    parameter int unsigned NumVC       = 4,
    parameter int unsigned NumVCWidth  = 2,
    parameter int unsigned VCDepth     = 2,
    parameter int unsigned CreditWidth = $clog2(VCDepth + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumVCWidth-1:0]        pref_vc_id_i,
    input  logic                         pref_only_i,
    output logic                         vc_sel_v_o,
    output logic [NumVCWidth-1:0]        vc_sel_id_o,
    input  logic                         assign_v_i,
    input  logic                         credit_v_i,
    input  logic [NumVCWidth-1:0]        credit_id_i,
    output logic [NumVC-1:0]             vc_avail_o,
    output logic [NumVC*CreditWidth-1:0] vc_credit_o,
    output logic                         err_o
);

`ifdef FLOO_VC_CREDIT_BYPASS_EN
    localparam logic BypassEn = 1'b1;
`else
    localparam logic BypassEn = 1'b0;
`endif

    localparam logic [CreditWidth-1:0] DepthC = CreditWidth'(VCDepth);

    logic [NumVC-1:0][CreditWidth-1:0] credit_q, credit_d;
    logic [NumVCWidth-1:0]             rr_ptr_q, rr_ptr_d;
    logic                              err_q, err_d;

    logic [NumVC-1:0] eff_avail;
    logic [NumVC-1:0] inc_vec, dec_vec;
    logic             pref_valid, pref_avail, cid_valid;
    logic             rr_found, sel_fallback, do_assign;
    int unsigned      rr_idx, rr_probe;

    // Availability seen by selection; a same-cycle return only counts when bypass is built in.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        eff_avail  = '0;
        pref_avail = 1'b0;
        pref_valid = 32'(pref_vc_id_i) < NumVC;
        cid_valid  = 32'(credit_id_i) < NumVC;
        for (int unsigned v = 0; v < NumVC; v++) begin
            eff_avail[v] = (credit_q[v] != '0) ||
                           (BypassEn && credit_v_i && (32'(credit_id_i) == v));
            if (32'(pref_vc_id_i) == v) pref_avail = eff_avail[v];
        end
    end

    // Round-robin search starting at rr_ptr_q, wrapping modulo NumVC.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = 0;
        rr_probe = 0;
        for (int unsigned i = 0; i < NumVC; i++) begin
            rr_probe = 32'(rr_ptr_q) + i;
            if (rr_probe >= NumVC) rr_probe = rr_probe - NumVC;
            for (int unsigned v = 0; v < NumVC; v++) begin
                if (!rr_found && (v == rr_probe) && eff_avail[v]) begin
                    rr_found = 1'b1;
                    rr_idx   = v;
                end
            end
        end
    end

    always_comb begin
        vc_sel_v_o   = 1'b0;
        vc_sel_id_o  = '0;
        sel_fallback = 1'b0;
        if (pref_valid && pref_avail) begin
            vc_sel_v_o  = 1'b1;
            vc_sel_id_o = pref_vc_id_i;
        end else if (pref_only_i) begin
            vc_sel_id_o = pref_vc_id_i;
        end else if (rr_found) begin
            vc_sel_v_o   = 1'b1;
            vc_sel_id_o  = NumVCWidth'(rr_idx);
            sel_fallback = 1'b1;
        end
    end

    assign do_assign = assign_v_i && vc_sel_v_o;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned v = 0; v < NumVC; v++) begin
            inc_vec[v] = credit_v_i && cid_valid && (32'(credit_id_i) == v);
            dec_vec[v] = do_assign && (32'(vc_sel_id_o) == v);
        end
    end

    // A same-VC assign and return cancel; counters saturate at both ends.
    always_comb begin
        credit_d = credit_q;
        rr_ptr_d = rr_ptr_q;
        err_d    = err_q;
        if (assign_v_i && !vc_sel_v_o) err_d = 1'b1;
        if (credit_v_i && !cid_valid) err_d = 1'b1;
        for (int unsigned v = 0; v < NumVC; v++) begin
            if (inc_vec[v] && !dec_vec[v]) begin
                if (credit_q[v] == DepthC) err_d = 1'b1;
                else                       credit_d[v] = credit_q[v] + 1'b1;
            end else if (dec_vec[v] && !inc_vec[v]) begin
                if (credit_q[v] != '0) credit_d[v] = credit_q[v] - 1'b1;
            end
        end
        if (do_assign && sel_fallback) begin
            if (rr_idx + 1 >= NumVC) rr_ptr_d = '0;
            else                     rr_ptr_d = NumVCWidth'(rr_idx + 1);
        end
    end

    // NOTE: the counters are ordinary flops, not a RAM, so they are reset alongside the rest of the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credit_q <= {NumVC{DepthC}};
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            credit_q <= credit_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        vc_avail_o = '0;
        for (int unsigned v = 0; v < NumVC; v++) vc_avail_o[v] = credit_q[v] != '0;
    end

    assign vc_credit_o = credit_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_floo_vc_credit_alloc.sv
// Directed, table-driven bench for floo_vc_credit_alloc (NumVC=4, NumVCWidth=3, VCDepth=2).
// Honours FLOO_VC_CREDIT_BYPASS_EN for the same-cycle credit reuse case.
module tb_floo_vc_credit_alloc;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [2:0] pref_vc_id_i = 3'd1;
    logic       pref_only_i = 1'b0;
    logic       vc_sel_v_o;
    logic [2:0] vc_sel_id_o;
    logic       assign_v_i = 1'b0;
    logic       credit_v_i = 1'b0;
    logic [2:0] credit_id_i = 3'd0;
    logic [3:0] vc_avail_o;
    logic [7:0] vc_credit_o;
    logic       err_o;

    int n_checks = 0;
    int n_errors = 0;

    floo_vc_credit_alloc #(
        .NumVC(4), .NumVCWidth(3), .VCDepth(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pref_vc_id_i(pref_vc_id_i), .pref_only_i(pref_only_i),
        .vc_sel_v_o(vc_sel_v_o), .vc_sel_id_o(vc_sel_id_o),
        .assign_v_i(assign_v_i),
        .credit_v_i(credit_v_i), .credit_id_i(credit_id_i),
        .vc_avail_o(vc_avail_o), .vc_credit_o(vc_credit_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0] pref;
        logic       only;
        logic       asg;
        logic       cv;
        logic [2:0] cid;
        logic       exp_v;
        logic [2:0] exp_id;
        logic [7:0] exp_credit;
        logic [3:0] exp_avail;
        logic       exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] pref, input logic only, input logic asg,
                                input logic cv, input logic [2:0] cid, input logic v,
                                input logic [2:0] id, input logic [7:0] cr,
                                input logic [3:0] av, input logic er);
        vec_t t;
        t = '{pref, only, asg, cv, cid, v, id, cr, av, er};
        return t;
    endfunction

    task automatic drive_idle();
        pref_only_i = 1'b0;
        assign_v_i  = 1'b0;
        credit_v_i  = 1'b0;
        credit_id_i = 3'd0;
    endtask

    // Drive on the falling edge, check selection before the rising edge, state after it.
    task automatic apply(input vec_t t, input string tag);
        @(negedge clk_i);
        pref_vc_id_i = t.pref;
        pref_only_i  = t.only;
        assign_v_i   = t.asg;
        credit_v_i   = t.cv;
        credit_id_i  = t.cid;
        #1;
        check({tag, ".sel_v"}, 32'(vc_sel_v_o), 32'(t.exp_v));
        check({tag, ".sel_id"}, 32'(vc_sel_id_o), 32'(t.exp_id));
        @(posedge clk_i);
        #1;
        check({tag, ".credit"}, 32'(vc_credit_o), 32'(t.exp_credit));
        check({tag, ".avail"}, 32'(vc_avail_o), 32'(t.exp_avail));
        check({tag, ".err"}, 32'(err_o), 32'(t.exp_err));
        drive_idle();
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        drive_idle();
        @(negedge clk_i);
        #2 rst_i = 1'b0;
    endtask

    initial begin
        logic [7:0] drain_cr [8];
        logic [3:0] drain_av [8];

        vecs[0]  = mk(3'd1, 0, 0, 0, 3'd0, 1, 3'd1, 8'hAA, 4'hF, 0);
        vecs[1]  = mk(3'd2, 0, 1, 0, 3'd0, 1, 3'd2, 8'h9A, 4'hF, 0);
        vecs[2]  = mk(3'd2, 0, 1, 0, 3'd0, 1, 3'd2, 8'h8A, 4'hB, 0);
        vecs[3]  = mk(3'd2, 0, 0, 0, 3'd0, 1, 3'd0, 8'h8A, 4'hB, 0);
        vecs[4]  = mk(3'd2, 0, 1, 0, 3'd0, 1, 3'd0, 8'h89, 4'hB, 0);
        vecs[5]  = mk(3'd2, 0, 0, 0, 3'd0, 1, 3'd1, 8'h89, 4'hB, 0);
        vecs[6]  = mk(3'd2, 0, 1, 0, 3'd0, 1, 3'd1, 8'h85, 4'hB, 0);
        vecs[7]  = mk(3'd2, 0, 0, 0, 3'd0, 1, 3'd3, 8'h85, 4'hB, 0);
        vecs[8]  = mk(3'd7, 0, 1, 0, 3'd0, 1, 3'd3, 8'h45, 4'hB, 0);
        vecs[9]  = mk(3'd1, 0, 1, 1, 3'd1, 1, 3'd1, 8'h45, 4'hB, 0);
        vecs[10] = mk(3'd0, 0, 1, 1, 3'd2, 1, 3'd0, 8'h54, 4'hE, 0);
        vecs[11] = mk(3'd0, 1, 0, 0, 3'd0, 0, 3'd0, 8'h54, 4'hE, 0);
        vecs[12] = mk(3'd4, 1, 0, 0, 3'd0, 0, 3'd4, 8'h54, 4'hE, 0);
        vecs[13] = mk(3'd2, 0, 0, 1, 3'd0, 1, 3'd2, 8'h55, 4'hF, 0);

        drain_cr = '{8'hA9, 8'hA8, 8'hA4, 8'hA0, 8'h90, 8'h80, 8'h40, 8'h00};
        drain_av = '{4'hF, 4'hE, 4'hE, 4'hC, 4'hC, 4'h8, 4'h8, 4'h0};

        // Reset released asynchronously in the middle of a cycle.
        #12 rst_i = 1'b0;
        #1;
        check("rst.credit", 32'(vc_credit_o), 32'h00AA);
        check("rst.avail", 32'(vc_avail_o), 32'hF);
        check("rst.sel_v", 32'(vc_sel_v_o), 32'd1);
        check("rst.sel_id", 32'(vc_sel_id_o), 32'd1);
        check("rst.err", 32'(err_o), 32'd0);

        for (int i = 0; i < 14; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // pref_only on an empty VC, then an illegal assign: sticky error.
        do_reset();
        apply(mk(3'd2, 0, 1, 0, 3'd0, 1, 3'd2, 8'h9A, 4'hF, 0), "po.a0");
        apply(mk(3'd2, 0, 1, 0, 3'd0, 1, 3'd2, 8'h8A, 4'hB, 0), "po.a1");
        apply(mk(3'd2, 1, 1, 0, 3'd0, 0, 3'd2, 8'h8A, 4'hB, 1), "po.bad");
        repeat (10) @(posedge clk_i);
        #1;
        check("po.err_sticky", 32'(err_o), 32'd1);
        check("po.credit_hold", 32'(vc_credit_o), 32'h008A);

        // Asynchronous reset mid-operation takes effect before any clock edge.
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        check("arst.credit", 32'(vc_credit_o), 32'h00AA);
        check("arst.err", 32'(err_o), 32'd0);
        @(negedge clk_i);
        #2 rst_i = 1'b0;

        // Overflowing return saturates; out-of-range return is ignored.
        apply(mk(3'd1, 0, 0, 1, 3'd0, 1, 3'd1, 8'hAA, 4'hF, 1), "sat");
        do_reset();
        #1;
        check("idr.err_pre", 32'(err_o), 32'd0);
        apply(mk(3'd1, 0, 0, 1, 3'd5, 1, 3'd1, 8'hAA, 4'hF, 1), "idr");

        // Drain every VC, then return a credit on VC3 with pref_only.
        do_reset();
        for (int k = 0; k < 8; k++)
            apply(mk(3'(k / 2), 0, 1, 0, 3'd0, 1, 3'(k / 2), drain_cr[k], drain_av[k], 0),
                  $sformatf("drain%0d", k));
        apply(mk(3'd7, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 4'h0, 0), "empty");
`ifdef FLOO_VC_CREDIT_BYPASS_EN
        apply(mk(3'd3, 1, 1, 1, 3'd3, 1, 3'd3, 8'h00, 4'h0, 0), "byp.reuse");
`else
        apply(mk(3'd3, 1, 0, 1, 3'd3, 0, 3'd3, 8'h40, 4'h8, 0), "nobyp.ret");
        apply(mk(3'd3, 1, 0, 0, 3'd0, 1, 3'd3, 8'h40, 4'h8, 0), "nobyp.next");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
